// File: rtl/hap_pkg.sv
// hap_pkg: shared constants and bundles for the HAP pipeline.
// Opcodes, instruction field positions and the decoded-instruction struct.
package hap_pkg;

   localparam int HAP_PC_W = 8;
   localparam int INSTR_W  = 16;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 11;
   localparam int RD_HI  = 10;
   localparam int RD_LO  = 8;
   localparam int R1_HI  = 7;
   localparam int R1_LO  = 5;
   localparam int R2_HI  = 4;
   localparam int R2_LO  = 2;

   localparam logic [4:0] OP_LT   = 5'b01011;
   localparam logic [4:0] OP_GT   = 5'b01100;
   localparam logic [4:0] OP_EQ   = 5'b01101;
   localparam logic [4:0] OP_GTE  = 5'b01110;
   localparam logic [4:0] OP_LTE  = 5'b01111;
   localparam logic [4:0] OP_NE   = 5'b10000;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef struct packed {
      logic [4:0]          opcode;
      logic [2:0]          rd;
      logic [2:0]          r1;
      logic [2:0]          r2;
      logic [HAP_PC_W-1:0] pc;
   } dec_t;

endpackage

// File: rtl/hap_fetch_buf.sv
// hap_fetch_buf: output register plus one skid entry for decoded words.
// Flush beats pop/push; order is preserved, nothing dropped otherwise.
module hap_fetch_buf
   import hap_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  dec_t       push_data,
   input  logic       pop,
   input  logic       flush,
   output logic       out_valid,
   output dec_t       out_data,
   output logic [1:0] count
);

   logic out_v;
   logic skid_v;
   dec_t out_q;
   dec_t skid_q;

   // fill output first, spill to skid, shift skid forward on pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else if (flush) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else if (pop && skid_v) begin
         out_q  <= skid_q;
         skid_v <= push;
         if (push) skid_q <= push_data;
      end else if (pop || !out_v) begin
         out_v <= push;
         if (push) out_q <= push_data;
      end else if (push) begin
         skid_v <= 1'b1;
         skid_q <= push_data;
      end
   end

   assign out_valid = out_v;
   assign out_data  = out_q;
   assign count     = {1'b0, out_v} + {1'b0, skid_v};

endmodule

// File: rtl/hap_fetch.sv
// hap_fetch: PC, instruction memory issue and decode for HAP.
// HAP_FETCH_HALT_EN enables stopping fetch on an accepted HALT.
module hap_fetch
   import hap_pkg::*;
#(
   parameter int PC_W = HAP_PC_W
) (
   input  logic            Clk,
   input  logic            Rst_n,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_rd,
   input  logic [15:0]     imem_data,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [4:0]      opcode,
   output logic [2:0]      rd,
   output logic [2:0]      r1,
   output logic [2:0]      r2,
   output logic [PC_W-1:0] dec_pc,
   output logic            halted
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] inf_pc;
   logic            inflight;
   logic            halted_q;
   logic            halt_acc;
   logic            pop;
   logic            push;
   logic            flush;
   logic            issue;
   logic [1:0]      count;
   logic [2:0]      occ_n;
   logic            out_v;
   dec_t            in_d;
   dec_t            out_d;
   logic            unused_bits;

   assign unused_bits = ^imem_data[1:0];

   assign pop   = out_v && dec_ready;
   assign flush = br_taken || halt_acc;
   assign push  = inflight && !flush;
   assign occ_n = {1'b0, count}
                + {2'b0, inflight}
                - {2'b0, pop};
   assign issue = Rst_n && !halted_q
               && !br_taken
               && (occ_n < 3'd2);

   // split the returning word into fields
   always_comb begin
      in_d        = '0;
      in_d.opcode = imem_data[OPC_HI:OPC_LO];
      in_d.rd     = imem_data[RD_HI:RD_LO];
      in_d.r1     = imem_data[R1_HI:R1_LO];
      in_d.r2     = imem_data[R2_HI:R2_LO];
      in_d.pc     = inf_pc;
   end

   // PC advance, redirect and in-flight tracking
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         pc       <= '0;
         inf_pc   <= '0;
         inflight <= 1'b0;
      end else begin
         if (br_taken)
            pc <= br_target;
         else if (issue)
            pc <= pc + PC_W'(1);
         if (issue)
            inf_pc <= pc;
         inflight <= issue && !halt_acc;
      end
   end

`ifdef HAP_FETCH_HALT_EN
   assign halt_acc = pop && (out_d.opcode == OP_HALT);

   // halt on an accepted HALT, resume only on redirect
   always_ff @(posedge Clk) begin
      if (!Rst_n)
         halted_q <= 1'b0;
      else if (br_taken)
         halted_q <= 1'b0;
      else if (halt_acc)
         halted_q <= 1'b1;
   end
`else
   assign halt_acc = 1'b0;
   assign halted_q = 1'b0;
`endif

   hap_fetch_buf u_buf (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .push      (push),
      .push_data (in_d),
      .pop       (pop),
      .flush     (flush),
      .out_valid (out_v),
      .out_data  (out_d),
      .count     (count)
   );

   assign imem_addr = pc;
   assign imem_rd   = issue;
   assign dec_valid = out_v;
   assign opcode    = out_d.opcode;
   assign rd        = out_d.rd;
   assign r1        = out_d.r1;
   assign r2        = out_d.r2;
   assign dec_pc    = out_d.pc;
   assign halted    = halted_q;

endmodule

// File: tb/tb_hap_fetch.sv
// tb_hap_fetch: scoreboard bench for hap_fetch.
// Expected stream = program order from memory, restarted on reset/branch.
module tb_hap_fetch;
   import hap_pkg::*;

   logic        clk = 1'b0;
   logic        Rst_n;
   logic [7:0]  imem_addr;
   logic        imem_rd;
   logic [15:0] imem_data;
   logic        br_taken;
   logic [7:0]  br_target;
   logic        dec_valid;
   logic        dec_ready;
   logic [4:0]  opcode;
   logic [2:0]  rd;
   logic [2:0]  r1;
   logic [2:0]  r2;
   logic [7:0]  dec_pc;
   logic        halted;

   always #5 clk = ~clk;

   hap_fetch dut (
      .Clk       (clk),
      .Rst_n     (Rst_n),
      .imem_addr (imem_addr),
      .imem_rd   (imem_rd),
      .imem_data (imem_data),
      .br_taken  (br_taken),
      .br_target (br_target),
      .dec_valid (dec_valid),
      .dec_ready (dec_ready),
      .opcode    (opcode),
      .rd        (rd),
      .r1        (r1),
      .r2        (r2),
      .dec_pc    (dec_pc),
      .halted    (halted)
   );

   logic [15:0] mem [256];

   // synchronous memory; junk on the bus when not read
   always @(posedge clk) begin
      if (imem_rd) imem_data <= mem[imem_addr];
      else         imem_data <= 16'($urandom);
   end

   typedef struct {
      logic [15:0] w;
      logic [7:0]  pc;
   } exp_t;

   exp_t q[$];
   int   nxt;
   bit   stop;
   int   checks = 0;
   int   errors = 0;
   int   accepts = 0;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, act, exp);
      end
   endfunction

   function automatic void add_one();
      exp_t e;
      e.w  = mem[nxt];
      e.pc = 8'(nxt);
      q.push_back(e);
`ifdef HAP_FETCH_HALT_EN
      if (e.w[15:11] == OP_HALT) stop = 1;
`endif
      nxt = (nxt + 1) % 256;
   endfunction

   function automatic void load(int start);
      q.delete();
      nxt  = start;
      stop = 0;
      for (int i = 0; i < 8; i++)
         if (!stop) add_one();
   endfunction

   logic        hold = 1'b0;
   logic [22:0] snap;

   // monitor: hold stability and in-order scoreboard on every accept
   always @(negedge clk) begin : mon
      exp_t e;
      if (hold)
         chk("hold", {dec_valid, opcode, rd, r1, r2, dec_pc}, snap);
      hold = Rst_n && dec_valid && !dec_ready && !br_taken;
      snap = {dec_valid, opcode, rd, r1, r2, dec_pc};
      if (Rst_n && dec_valid && dec_ready) begin
         accepts++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got pc %0h want none", dec_pc);
         end else begin
            e = q.pop_front();
            chk("sb_pc", dec_pc, e.pc);
            chk("sb_op", opcode, e.w[15:11]);
            chk("sb_rd", rd, e.w[10:8]);
            chk("sb_r1", r1, e.w[7:5]);
            chk("sb_r2", r2, e.w[4:2]);
            while (q.size() < 8 && !stop) add_one();
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // one reset edge, then cycle 0/1/2 timing
   task automatic do_reset();
      Rst_n     = 1'b0;
      br_taken  = 1'b0;
      dec_ready = 1'b0;
      q.delete();
      stop = 1;
      neg();
      chk("rst_rd", imem_rd, 0);
      step();
      Rst_n     = 1'b1;
      dec_ready = 1'b1;
      load(0);
      neg();
      chk("c0_valid", dec_valid, 0);
      chk("c0_fields", {opcode, rd, r1, r2, dec_pc}, 0);
      chk("c0_halted", halted, 0);
      chk("c0_rd", imem_rd, 1);
      chk("c0_addr", imem_addr, 0);
      step();
      neg();
      chk("c1_valid", dec_valid, 0);
      step();
      neg();
      chk("c2_valid", dec_valid, 1);
      chk("c2_pc", dec_pc, 0);
   endtask

   // redirect and its t+1..t+3 timing
   task automatic br_check(logic [7:0] t);
      br_taken  = 1'b1;
      br_target = t;
      dec_ready = 1'b0;
      load(int'(t));
      neg();
      chk("br_rd0", imem_rd, 0);
      step();
      br_taken  = 1'b0;
      dec_ready = 1'b1;
      neg();
      chk("br_addr1", imem_addr, t);
      chk("br_rd1", imem_rd, 1);
      chk("br_valid1", dec_valid, 0);
      chk("br_halted", halted, 0);
      step();
      neg();
      chk("br_valid2", dec_valid, 0);
      chk("br_addr2", imem_addr, 8'(t + 8'd1));
      step();
      neg();
      chk("br_valid3", dec_valid, 1);
      chk("br_pc3", dec_pc, t);
      chk("br_addr3", imem_addr, 8'(t + 8'd2));
   endtask

   initial begin
      int n0;
      int r;
      logic [15:0] w;
      Rst_n     = 1'b0;
      br_taken  = 1'b0;
      br_target = 8'h00;
      dec_ready = 1'b1;
      for (int k = 0; k < 256; k++)
         mem[k] = {OP_LT, 3'(k % 8), 3'd3, 3'd5, 2'b00};
      step();
      step();

      do_reset();
      chk("c2_op", opcode, OP_LT);
      chk("c2_r1", r1, 3);
      chk("c2_r2", r2, 5);

      step();
      n0 = accepts;
      repeat (10) step();
      chk("thru", accepts - n0, 10);

      dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         neg();
         chk("stall_rd", imem_rd, 0);
         step();
      end
      dec_ready = 1'b1;
      neg();
      chk("rel_rd", imem_rd, 1);
      repeat (10) step();

      br_check(8'h40);
      step();
      dec_ready = 1'b0;
      step();
      step();
      br_check(8'h80);
      step();
      br_check(8'hFE);
      repeat (4) step();

      dec_ready = 1'b0;
      repeat (3) step();
      do_reset();

      w = {OP_HALT, 3'd1, 3'd2, 3'd3, 2'b00};
      mem[3] = w;
      step();
      do_reset();
`ifdef HAP_FETCH_HALT_EN
      repeat (4) begin
         step();
         neg();
      end
      for (int i = 0; i < 8; i++) begin
         chk("halt_flag", halted, 1);
         chk("halt_rd", imem_rd, 0);
         chk("halt_valid", dec_valid, 0);
         step();
         neg();
      end
      step();
      br_check(8'h10);
`else
      repeat (3) begin
         step();
         neg();
      end
      chk("nohalt_pc", dec_pc, 3);
      chk("nohalt_op", opcode, OP_HALT);
      repeat (5) begin
         step();
         neg();
      end
      chk("nohalt_valid", dec_valid, 1);
      chk("nohalt_pc8", dec_pc, 8);
      chk("nohalt_flag", halted, 0);
`endif
      step();

      for (int k = 0; k < 256; k++) begin
         w = 16'($urandom);
         if (w[15:11] == OP_HALT) w[15] = 1'b0;
         mem[k] = w;
      end
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         step();
         r = int'($urandom % 1000);
         if (r < 3)
            do_reset();
         else if (r < 25)
            br_check(8'($urandom));
         else
            dec_ready = ($urandom % 10) < 7;
      end

      step();
      dec_ready = 1'b1;
      repeat (3) step();
      n0 = accepts;
      repeat (20) step();
      chk("thru_end", accepts - n0, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hap_fetch.md
# hap_fetch

Instruction fetch/decode stage of the Harvard Architecture Processor. It owns the program counter and reads the synchronous instruction memory. It splits each 16-bit instruction into opcode and register fields and presents them to the execute stage, which includes the compare unit, through a valid/ready handshake. Branch redirects come back from the execute stage when a compare result resolves a taken branch.

## Interface
- PC_W, 8, program counter / instruction address width
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  synchronous, active-low reset
- imem_addr  out  PC_W  instruction memory address (= PC)
- imem_rd  out  1  instruction memory read request
- imem_data  in  16  instruction word, valid the cycle after imem_rd
- br_taken  in  1  single-cycle redirect request from execute
- br_target  in  PC_W  redirect address, sampled with br_taken
- dec_valid  out  1  decoded instruction available
- dec_ready  in  1  execute stage accepts decoded instruction
- opcode  out  5  instr[15:11]
- rd  out  3  instr[10:8]
- r1  out  3  instr[7:5]
- r2  out  3  instr[4:2]; instr[1:0] ignored
- dec_pc  out  PC_W  address of the presented instruction
- halted  out  1  fetch stopped by HALT

## Operation
- Reset (Rst_n low at an edge) sets PC=0, dec_valid=0, opcode/rd/r1/r2/dec_pc=0, halted=0, and clears the buffer and in-flight flag. imem_rd is 0 while Rst_n is low.
- The 2-entry buffer is the output register plus one skid entry. Occupancy `occ` = dec_valid + skid_valid + inflight.
- Issue rule: imem_rd=1 when !halted && !br_taken && (occ − (dec_valid&&dec_ready)) < 2.
  - On issue, PC <= PC+1. The PC wraps from 2^PC_W−1 to 0.
  - inflight <= 1 and the issue address is recorded for dec_pc.
- Response cycle:
  - The word goes to the output register if it is empty or being popped this cycle. Otherwise it goes to the skid entry.
  - On a pop with skid full, skid moves to the output. The new response then goes to skid.
- Order is strictly preserved. A response is never dropped except on flush.
- Redirect priority is reset > br_taken > normal.
  - br_taken: PC <= br_target; dec_valid, skid and inflight clear; any response arriving the next cycle is discarded.
  - halted clears.
  - No issue occurs in the br_taken cycle.
- Handshake: while dec_valid && !dec_ready, all outputs hold stable. dec_valid is never withdrawn except by br_taken or reset.

## Timing
- Fetch latency: imem_rd at cycle t, then dec_valid from t+2.
- After reset release, the first imem_rd (addr 0) occurs in cycle 0 and dec_valid rises in cycle 2.
- Sustained throughput is 1 instruction/cycle with dec_ready held high.
- Redirect: br_taken in cycle t gives imem_rd at br_target in t+1 and the first new dec_valid in t+3.
- A stall of any length loses no instruction. On release, buffered entries drain one per cycle and issue resumes without bubble beyond buffer refill.

## Configuration
- HAP_FETCH_HALT_EN defined:
  - An accepted instruction (dec_valid && dec_ready) with opcode 5'b11111 sets halted in the next cycle.
  - Issue stops, and skid and inflight are flushed.
  - halted clears only on reset or br_taken.
- Undefined: opcode 5'b11111 is an ordinary instruction and halted is tied 0.

## Structure
- Shared package hap_pkg holds:
  - opcode constants OP_LT=01011, OP_GT=01100, OP_EQ=01101, OP_GTE=01110, OP_LTE=01111, OP_NE=10000, OP_HALT=11111;
  - instruction width 16 and field bit positions;
  - a decoded-instruction struct (opcode, rd, r1, r2, pc).
- One sub-module, hap_fetch_buf: the 2-entry output/skid buffer with push, pop, flush and occupancy count. PC, issue logic and halt live in hap_fetch.

## Test plan
- Reset, memory word k = {OP_LT, 3'd(k%8), 3'd3, 3'd5, 2'b0}, dec_ready=1 → dec_valid rises cycle 2; dec_pc 0,1,2,… on consecutive cycles, opcode=01011, r1=3, r2=5.
- dec_ready low for 5 cycles mid-stream → outputs frozen, at most 2 words buffered, imem_rd low; after release dec_pc continues with no gap or duplicate.
- br_taken with br_target=8'h40 while buffer full and a read in flight → next imem_addr=8'h40; the first dec_pc after the flush is 8'h40; no stale instruction presented.
- PC=8'hFF issue → next imem_addr=8'h00; dec_pc sequence FF, 00.
- Rst_n low for one cycle mid-stall → all outputs 0 the next cycle; refetch starts at address 0.
- HALT_EN: OP_HALT at address 3 accepted → halted=1 and no imem_rd afterward; br_taken to 8'h10 resumes fetch. Without the macro, address 3 presents opcode 11111 and fetch continues.
